multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, SHALL set the maximum wait cycles for imem_ready or dmem_ready before a bus error; legal range 2..255.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 ir_opcode  input  7  opcode field of the instruction register, valid from DECODE onward.
REQ-005 branch_taken  input  1  branch comparison result, sampled in EXEC.
REQ-006 imem_req / imem_ready  output / input  1 / 1  instruction fetch request and completion.
REQ-007 dmem_req / dmem_we / dmem_ready  output / output / input  1 / 1 / 1  data access request, write qualifier and completion.
REQ-008 ir_we  output  1  instruction register load strobe.
REQ-009 pc_we  output  1  PC update strobe; pc_sel  output  2  source: 0 PC+4, 1 PC+imm, 2 ALU result.
REQ-010 alu_src_b  output  1  ALU operand B: 0 rs2, 1 immediate.
REQ-011 rf_we  output  1  register file write; wb_sel  output  2  source: 0 ALU, 1 load data, 2 PC+4, 3 immediate.
REQ-012 state_o  output  3  current state encoding; halted, illegal_instr, bus_err  output  1 each  sticky trap flags.
REQ-013 instret  output  32  retired instruction count (REQ-030).

Function
REQ-014 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; encodings 6..7 SHALL go to TRAP with illegal_instr=1.
REQ-015 All strobes and requests SHALL be combinational functions of the registered state and ir_opcode; outside the states listed below, each strobe SHALL be 0.
REQ-016 FETCH: imem_req=1 held until imem_ready=1; in the ready cycle ir_we=1 and next state is DECODE.
REQ-017 DECODE: legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111 and 1100111; legal -> EXEC, any other value -> TRAP with illegal_instr=1.
REQ-018 EXEC: alu_src_b=0 for 0110011 and 1100011, otherwise 1; load/store -> MEM; branch -> FETCH with pc_we=1 and pc_sel=branch_taken?1:0; all other opcodes -> WB.
REQ-019 MEM: dmem_req=1 and dmem_we=(opcode==0100011) held until dmem_ready=1; store -> FETCH with pc_we=1 and pc_sel=0; load -> WB.
REQ-020 WB: rf_we=1 and pc_we=1 for one cycle, then FETCH; wb_sel selects load=1, JAL/JALR=2, LUI=3, else 0; pc_sel selects JAL=1, JALR=2, else 0.
REQ-021 Timeout: an 8-bit wait counter SHALL clear on state entry and increment each FETCH/MEM cycle without ready; ready absent for MEM_TIMEOUT consecutive cycles SHALL cause TRAP with bus_err=1.
REQ-022 Ready in the cycle the counter reaches MEM_TIMEOUT-1 SHALL complete normally, because ready takes priority over timeout.
REQ-023 imem_ready or dmem_ready while its request is 0 SHALL be ignored.
REQ-024 TRAP: halted=1 and all strobes 0; TRAP SHALL be exited only by rst.
REQ-025 An instruction SHALL retire on the transition into FETCH from EXEC, MEM or WB.

Reset
REQ-026 With rst=1 at a clock edge, the state SHALL become FETCH, the wait counter 0, and halted, illegal_instr and bus_err 0.
REQ-027 While rst=1, every request and strobe output SHALL be forced to 0 combinationally, regardless of state.
REQ-028 A reset asserted mid-access SHALL abandon the access; the next cycle SHALL begin a fresh FETCH with no pc_we.
REQ-029 instret SHALL reset to 0.

Configuration
REQ-030 With PERF_CNT_EN defined, instret SHALL increment by 1 per retirement (REQ-025) and wrap from 0xFFFFFFFF to 0.
REQ-031 Without PERF_CNT_EN, instret SHALL be driven constant 0 and the counter logic SHALL be omitted; all other behaviour is identical.

Verification
REQ-032 ADDI (opcode 0010011), imem_ready on the first request cycle -> states 0,1,2,4,0 across 5 cycles; alu_src_b=1 in EXEC; rf_we=1, wb_sel=0, pc_sel=0 in WB.
REQ-033 LW with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we=0, then WB with wb_sel=1; with PERF_CNT_EN, instret advances by 1.
REQ-034 BEQ with branch_taken=1 -> pc_we=1 and pc_sel=1 in EXEC, no WB or rf_we; with branch_taken=0 -> pc_sel=0.
REQ-035 ir_opcode=0001011 -> TRAP after DECODE, illegal_instr=1, halted=1, no strobes thereafter until rst.
REQ-036 imem_ready held low with MEM_TIMEOUT=16 -> bus_err=1 after exactly 16 FETCH cycles; a repeat with ready in cycle 16 -> normal DECODE.
REQ-037 rst pulsed during MEM of a store -> dmem_req=0 in the rst cycle, state_o=0 next cycle, no pc_we issued.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multicycle RV32-style datapath. Each instruction moves
// through FETCH -> DECODE -> EXEC -> [MEM] -> [WB] -> FETCH. Any fault enters
// TRAP, which only rst can leave. Faults are an illegal opcode, a memory
// timeout, or a corrupt state encoding.
//
// Optional feature macro: PERF_CNT_EN
//   defined   : instret counts retired instructions and wraps at 2^32
//   undefined : instret is tied to 0 and the counter logic is not built
//
// Handshake (imem and dmem): a request stays high until its ready is seen
// high in the same cycle. The transfer completes in that cycle. A ready that
// arrives while its request is low is ignored.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   ir_opcode[6:0]                  opcode field of the instruction register
//   branch_taken                    branch comparison result (used in EXEC)
//   imem_req / imem_ready           instruction fetch handshake
//   dmem_req / dmem_we / dmem_ready data access handshake and write qualifier
//   ir_we                           instruction register load strobe
//   pc_we, pc_sel[1:0]              PC update; 0 PC+4, 1 PC+imm, 2 ALU
//   alu_src_b                       ALU operand B; 0 rs2, 1 immediate
//   rf_we, wb_sel[1:0]              register write; 0 ALU, 1 load, 2 PC+4, 3 imm
//   state_o[2:0]                    current FSM state (debug visibility)
//   halted, illegal_instr, bus_err  sticky trap flags
//   instret[31:0]                   retired instruction count
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16  // legal range 2..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  ir_opcode,
  input  logic        branch_taken,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        alu_src_b,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state_o,
  output logic        halted,
  output logic        illegal_instr,
  output logic        bus_err,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // The wait counter holds the number of ready-less cycles already spent in
  // the current state. The cycle in which it equals this value is the
  // MEM_TIMEOUT-th cycle without ready. Ready in that cycle still wins.
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  // Opcode classification
  logic is_r, is_imm, is_load, is_store, is_branch;
  logic is_lui, is_auipc, is_jal, is_jalr, is_legal;

  always_comb begin
    is_r      = (ir_opcode == OP_R);
    is_imm    = (ir_opcode == OP_IMM);
    is_load   = (ir_opcode == OP_LOAD);
    is_store  = (ir_opcode == OP_STORE);
    is_branch = (ir_opcode == OP_BRANCH);
    is_lui    = (ir_opcode == OP_LUI);
    is_auipc  = (ir_opcode == OP_AUIPC);
    is_jal    = (ir_opcode == OP_JAL);
    is_jalr   = (ir_opcode == OP_JALR);
    is_legal  = is_r | is_imm | is_load | is_store | is_branch |
                is_lui | is_auipc | is_jal | is_jalr;
  end

  assign state_o = state;

  // Strobes and requests depend only on the registered state, ir_opcode and
  // the qualifying inputs. rst forces all of them low, so a reset in the
  // middle of an access drops the request in the same cycle.
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    alu_src_b = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    if (!rst) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        EXEC: begin
          alu_src_b = ~(is_r | is_branch);
          if (is_branch) begin
            pc_we  = 1'b1;
            pc_sel = branch_taken ? 2'd1 : 2'd0;
          end
        end
        MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          // A store finishes here, so the PC advances to PC+4 on completion.
          if (is_store && dmem_ready) pc_we = 1'b1;
        end
        WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
          if (is_load)                wb_sel = 2'd1;
          else if (is_jal || is_jalr) wb_sel = 2'd2;
          else if (is_lui)            wb_sel = 2'd3;
          else                        wb_sel = 2'd0;
          if (is_jal)       pc_sel = 2'd1;
          else if (is_jalr) pc_sel = 2'd2;
          else              pc_sel = 2'd0;
        end
        default: ;
      endcase
    end
  end

  // State register, wait counter and sticky trap flags.
  // wait_cnt is cleared on every state change, so each wait window starts
  // from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      wait_cnt      <= 8'd0;
      halted        <= 1'b0;
      illegal_instr <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            state    <= DECODE;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state    <= TRAP;
            wait_cnt <= 8'd0;
            bus_err  <= 1'b1;
            halted   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DECODE: begin
          wait_cnt <= 8'd0;
          if (is_legal) begin
            state <= EXEC;
          end else begin
            state         <= TRAP;
            illegal_instr <= 1'b1;
            halted        <= 1'b1;
          end
        end
        EXEC: begin
          wait_cnt <= 8'd0;
          if (is_load || is_store) state <= MEM;
          else if (is_branch)      state <= FETCH;
          else                     state <= WB;
        end
        MEM: begin
          if (dmem_ready) begin
            state    <= is_store ? FETCH : WB;
            wait_cnt <= 8'd0;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            state    <= TRAP;
            wait_cnt <= 8'd0;
            bus_err  <= 1'b1;
            halted   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        WB: begin
          wait_cnt <= 8'd0;
          state    <= FETCH;
        end
        TRAP: begin
          wait_cnt <= 8'd0;
          halted   <= 1'b1;
        end
        default: begin
          // Encodings 6 and 7 can only come from corruption.
          state         <= TRAP;
          wait_cnt      <= 8'd0;
          illegal_instr <= 1'b1;
          halted        <= 1'b1;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // An instruction retires on the transition back into FETCH. That happens
  // for a branch in EXEC, for a completed store in MEM, and for any WB.
  logic retire;

  always_comb begin
    retire = 1'b0;
    if (!rst) begin
      case (state)
        EXEC:    retire = is_branch;
        MEM:     retire = is_store & dmem_ready;
        WB:      retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         instret <= 32'd0;
    else if (retire) instret <= instret + 32'd1;
  end
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed testbench for multicycle_ctrl with MEM_TIMEOUT = 16.
// Inputs change 1 time unit after each rising edge. Outputs are sampled
// 1 time unit later, well away from the next active edge.
// If PERF_CNT_EN is defined for the build, instret is expected to count;
// otherwise it is expected to stay 0.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [6:0]  ir_opcode;
  logic        branch_taken;
  logic        imem_req;
  logic        imem_ready;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        alu_src_b;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic [2:0]  state_o;
  logic        halted;
  logic        illegal_instr;
  logic        bus_err;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;
  int exp_retired = 0;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BAD    = 7'b0001011;

  // Strobe vector layout, MSB first:
  // imem_req ir_we dmem_req dmem_we pc_we pc_sel[1:0] alu_src_b rf_we wb_sel[1:0]
  localparam logic [10:0] S_NONE       = 11'b0_0_0_0_0_00_0_0_00;
  localparam logic [10:0] S_FETCH_WAIT = 11'b1_0_0_0_0_00_0_0_00;
  localparam logic [10:0] S_FETCH_RDY  = 11'b1_1_0_0_0_00_0_0_00;
  localparam logic [10:0] S_EXEC_IMM   = 11'b0_0_0_0_0_00_1_0_00;
  localparam logic [10:0] S_EXEC_RS2   = 11'b0_0_0_0_0_00_0_0_00;
  localparam logic [10:0] S_BR_TAKEN   = 11'b0_0_0_0_1_01_0_0_00;
  localparam logic [10:0] S_BR_NOT     = 11'b0_0_0_0_1_00_0_0_00;
  localparam logic [10:0] S_MEM_LOAD   = 11'b0_0_1_0_0_00_0_0_00;
  localparam logic [10:0] S_MEM_ST_W   = 11'b0_0_1_1_0_00_0_0_00;
  localparam logic [10:0] S_MEM_ST_R   = 11'b0_0_1_1_1_00_0_0_00;

  multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .ir_opcode    (ir_opcode),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ready   (dmem_ready),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alu_src_b    (alu_src_b),
    .rf_we        (rf_we),
    .wb_sel       (wb_sel),
    .state_o      (state_o),
    .halted       (halted),
    .illegal_instr(illegal_instr),
    .bus_err      (bus_err),
    .instret      (instret)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] strobes();
    return {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel,
            alu_src_b, rf_we, wb_sel};
  endfunction

  function automatic logic [31:0] exp_instret();
`ifdef PERF_CNT_EN
    return 32'(exp_retired);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [10:0] wb_vec(input logic [1:0] ps, input logic [1:0] ws);
    return {5'b00001, ps, 1'b0, 1'b1, ws};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    branch_taken = 1'b0;
    step();
    rst = 1'b0;
    exp_retired = 0;
  endtask

  // Fetch with ready on the first request cycle, then pass through DECODE.
  // Returns with the FSM one cycle past DECODE.
  task automatic fetch_decode(input logic [6:0] op, input string tag);
    ir_opcode = op;
    imem_ready = 1'b1;
    #1;
    checks++;
    if (state_o !== 3'd0) begin
      errors++; $display("FAIL %s_fetch_state got %0d exp 0", tag, state_o);
    end
    checks++;
    if (strobes() !== S_FETCH_RDY) begin
      errors++; $display("FAIL %s_fetch_strobes got %b exp %b", tag, strobes(), S_FETCH_RDY);
    end
    step();
    imem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd1) begin
      errors++; $display("FAIL %s_decode_state got %0d exp 1", tag, state_o);
    end
    checks++;
    if (strobes() !== S_NONE) begin
      errors++; $display("FAIL %s_decode_strobes got %b exp %b", tag, strobes(), S_NONE);
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ir_opcode = OP_IMM;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    branch_taken = 1'b1;
    step();
    step();
    checks++;
    if (state_o !== 3'd0) begin
      errors++; $display("FAIL reset_state got %0d exp 0", state_o);
    end
    checks++;
    if ({halted, illegal_instr, bus_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {halted, illegal_instr, bus_err});
    end
    checks++;
    if (strobes() !== S_NONE) begin
      errors++; $display("FAIL reset_forced_strobes got %b exp %b", strobes(), S_NONE);
    end
    checks++;
    if (instret !== 32'd0) begin
      errors++; $display("FAIL reset_instret got %0d exp 0", instret);
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    branch_taken = 1'b0;
    rst = 1'b0;
    exp_retired = 0;
    #1;
    checks++;
    if (strobes() !== S_FETCH_WAIT) begin
      errors++; $display("FAIL reset_release_strobes got %b exp %b", strobes(), S_FETCH_WAIT);
    end
  endtask

  task automatic test_addi();
    fetch_decode(OP_IMM, "addi");
    checks++;
    if (state_o !== 3'd2 || strobes() !== S_EXEC_IMM) begin
      errors++; $display("FAIL addi_exec got state %0d strobes %b exp state 2 strobes %b", state_o, strobes(), S_EXEC_IMM);
    end
    step();
    checks++;
    if (state_o !== 3'd4 || strobes() !== wb_vec(2'd0, 2'd0)) begin
      errors++; $display("FAIL addi_wb got state %0d strobes %b exp state 4 strobes %b", state_o, strobes(), wb_vec(2'd0, 2'd0));
    end
    step();
    exp_retired++;
    checks++;
    if (state_o !== 3'd0 || instret !== exp_instret()) begin
      errors++; $display("FAIL addi_retire got state %0d instret %0d exp state 0 instret %0d", state_o, instret, exp_instret());
    end
  endtask

  task automatic test_lw_delayed();
    int req_cycles = 0;
    fetch_decode(OP_LOAD, "lw");
    checks++;
    if (strobes() !== S_EXEC_IMM) begin
      errors++; $display("FAIL lw_exec_strobes got %b exp %b", strobes(), S_EXEC_IMM);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      #1;
      checks++;
      if (state_o !== 3'd3 || strobes() !== S_MEM_LOAD) begin
        errors++; $display("FAIL lw_mem_cycle%0d got state %0d strobes %b exp state 3 strobes %b", i, state_o, strobes(), S_MEM_LOAD);
      end
      if (dmem_req) req_cycles++;
      step();
    end
    dmem_ready = 1'b0;
    checks++;
    if (req_cycles !== 4) begin
      errors++; $display("FAIL lw_req_cycles got %0d exp 4", req_cycles);
    end
    checks++;
    if (state_o !== 3'd4 || strobes() !== wb_vec(2'd0, 2'd1)) begin
      errors++; $display("FAIL lw_wb got state %0d strobes %b exp state 4 strobes %b", state_o, strobes(), wb_vec(2'd0, 2'd1));
    end
    step();
    exp_retired++;
    checks++;
    if (state_o !== 3'd0 || instret !== exp_instret()) begin
      errors++; $display("FAIL lw_retire got state %0d instret %0d exp state 0 instret %0d", state_o, instret, exp_instret());
    end
  endtask

  task automatic test_branch();
    for (int t = 1; t >= 0; t--) begin
      fetch_decode(OP_BRANCH, "beq");
      branch_taken = (t == 1);
      #1;
      checks++;
      if (state_o !== 3'd2 || strobes() !== (t == 1 ? S_BR_TAKEN : S_BR_NOT)) begin
        errors++; $display("FAIL beq_exec_taken%0d got state %0d strobes %b exp %b", t, state_o, strobes(), (t == 1 ? S_BR_TAKEN : S_BR_NOT));
      end
      step();
      branch_taken = 1'b0;
      exp_retired++;
      checks++;
      if (state_o !== 3'd0 || instret !== exp_instret()) begin
        errors++; $display("FAIL beq_next_taken%0d got state %0d instret %0d exp state 0 instret %0d", t, state_o, instret, exp_instret());
      end
    end
  endtask

  task automatic test_wb_select();
    logic [6:0]  ops [5] = '{OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_R};
    logic [1:0]  wbs [5] = '{2'd2,   2'd2,    2'd3,   2'd0,     2'd0};
    logic [1:0]  pcs [5] = '{2'd1,   2'd2,    2'd0,   2'd0,     2'd0};
    logic [10:0] exs [5] = '{S_EXEC_IMM, S_EXEC_IMM, S_EXEC_IMM, S_EXEC_IMM, S_EXEC_RS2};
    for (int k = 0; k < 5; k++) begin
      fetch_decode(ops[k], "wbsel");
      checks++;
      if (state_o !== 3'd2 || strobes() !== exs[k]) begin
        errors++; $display("FAIL wbsel_exec_op%b got state %0d strobes %b exp %b", ops[k], state_o, strobes(), exs[k]);
      end
      step();
      checks++;
      if (state_o !== 3'd4 || strobes() !== wb_vec(pcs[k], wbs[k])) begin
        errors++; $display("FAIL wbsel_wb_op%b got state %0d strobes %b exp %b", ops[k], state_o, strobes(), wb_vec(pcs[k], wbs[k]));
      end
      step();
      exp_retired++;
      checks++;
      if (state_o !== 3'd0 || instret !== exp_instret()) begin
        errors++; $display("FAIL wbsel_retire_op%b got state %0d instret %0d exp %0d", ops[k], state_o, instret, exp_instret());
      end
    end
  endtask

  task automatic test_store();
    fetch_decode(OP_STORE, "sw");
    step();
    dmem_ready = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd3 || strobes() !== S_MEM_ST_W) begin
      errors++; $display("FAIL sw_mem_wait got state %0d strobes %b exp state 3 strobes %b", state_o, strobes(), S_MEM_ST_W);
    end
    step();
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (strobes() !== S_MEM_ST_R) begin
      errors++; $display("FAIL sw_mem_ready got %b exp %b", strobes(), S_MEM_ST_R);
    end
    step();
    dmem_ready = 1'b0;
    exp_retired++;
    checks++;
    if (state_o !== 3'd0 || instret !== exp_instret()) begin
      errors++; $display("FAIL sw_retire got state %0d instret %0d exp state 0 instret %0d", state_o, instret, exp_instret());
    end
  endtask

  task automatic test_ignore_ready();
    // dmem_ready during FETCH must not complete the fetch
    ir_opcode = OP_IMM;
    dmem_ready = 1'b1;
    imem_ready = 1'b0;
    #1;
    checks++;
    if (strobes() !== S_FETCH_WAIT) begin
      errors++; $display("FAIL ignore_fetch_strobes got %b exp %b", strobes(), S_FETCH_WAIT);
    end
    step();
    checks++;
    if (state_o !== 3'd0) begin
      errors++; $display("FAIL ignore_fetch_state got %0d exp 0", state_o);
    end
    imem_ready = 1'b1;
    dmem_ready = 1'b0;
    step();
    // Both readies high during DECODE: no strobes, normal progress
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (state_o !== 3'd1 || strobes() !== S_NONE) begin
      errors++; $display("FAIL ignore_decode got state %0d strobes %b exp state 1 strobes %b", state_o, strobes(), S_NONE);
    end
    step();
    imem_ready = 1'b0;
    step();
    dmem_ready = 1'b0;
    checks++;
    if (state_o !== 3'd4) begin
      errors++; $display("FAIL ignore_exec_next got %0d exp 4", state_o);
    end
    step();
    exp_retired++;
  endtask

  task automatic test_timeout();
    apply_reset();
    ir_opcode = OP_IMM;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (state_o !== 3'd0 || strobes() !== S_FETCH_WAIT) begin
        errors++; $display("FAIL tmo_fetch_cycle%0d got state %0d strobes %b exp state 0", i + 1, state_o, strobes());
      end
      step();
    end
    checks++;
    if (state_o !== 3'd5 || {halted, illegal_instr, bus_err} !== 3'b101 || strobes() !== S_NONE) begin
      errors++; $display("FAIL tmo_trap got state %0d flags %b strobes %b exp state 5 flags 101", state_o, {halted, illegal_instr, bus_err}, strobes());
    end
    // Ready in the 16th cycle still completes
    apply_reset();
    for (int i = 0; i < 15; i++) step();
    imem_ready = 1'b1;
    #1;
    checks++;
    if (state_o !== 3'd0 || strobes() !== S_FETCH_RDY) begin
      errors++; $display("FAIL tmo_edge_fetch got state %0d strobes %b exp state 0 strobes %b", state_o, strobes(), S_FETCH_RDY);
    end
    step();
    imem_ready = 1'b0;
    checks++;
    if (state_o !== 3'd1 || bus_err !== 1'b0) begin
      errors++; $display("FAIL tmo_edge_decode got state %0d bus_err %b exp state 1 bus_err 0", state_o, bus_err);
    end
    // Data side: load never ready traps after 16 MEM cycles
    apply_reset();
    fetch_decode(OP_LOAD, "tmo_lw");
    step();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (state_o !== 3'd3) begin
        errors++; $display("FAIL tmo_mem_cycle%0d got state %0d exp 3", i + 1, state_o);
      end
      step();
    end
    checks++;
    if (state_o !== 3'd5 || bus_err !== 1'b1 || halted !== 1'b1) begin
      errors++; $display("FAIL tmo_mem_trap got state %0d bus_err %b halted %b exp 5 1 1", state_o, bus_err, halted);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    fetch_decode(OP_BAD, "illegal");
    checks++;
    if (state_o !== 3'd5 || {halted, illegal_instr, bus_err} !== 3'b110) begin
      errors++; $display("FAIL illegal_trap got state %0d flags %b exp state 5 flags 110", state_o, {halted, illegal_instr, bus_err});
    end
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ir_opcode = (i[0]) ? OP_BRANCH : OP_IMM;
      #1;
      checks++;
      if (state_o !== 3'd5 || strobes() !== S_NONE) begin
        errors++; $display("FAIL illegal_hold%0d got state %0d strobes %b exp state 5 strobes 0", i, state_o, strobes());
      end
      step();
    end
    apply_reset();
    checks++;
    if (state_o !== 3'd0 || {halted, illegal_instr, bus_err} !== 3'b000) begin
      errors++; $display("FAIL illegal_reset got state %0d flags %b exp state 0 flags 000", state_o, {halted, illegal_instr, bus_err});
    end
  endtask

  task automatic test_reset_mid_store();
    apply_reset();
    fetch_decode(OP_STORE, "rst_sw");
    step();
    #1;
    checks++;
    if (state_o !== 3'd3 || strobes() !== S_MEM_ST_W) begin
      errors++; $display("FAIL rst_sw_mem got state %0d strobes %b exp state 3 strobes %b", state_o, strobes(), S_MEM_ST_W);
    end
    rst = 1'b1;
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (strobes() !== S_NONE) begin
      errors++; $display("FAIL rst_sw_forced got %b exp %b", strobes(), S_NONE);
    end
    step();
    rst = 1'b0;
    dmem_ready = 1'b0;
    exp_retired = 0;
    #1;
    checks++;
    if (state_o !== 3'd0 || strobes() !== S_FETCH_WAIT) begin
      errors++; $display("FAIL rst_sw_refetch got state %0d strobes %b exp state 0 strobes %b", state_o, strobes(), S_FETCH_WAIT);
    end
    checks++;
    if (instret !== exp_instret()) begin
      errors++; $display("FAIL rst_sw_instret got %0d exp %0d", instret, exp_instret());
    end
  endtask

  initial begin
    rst = 1'b1;
    ir_opcode = 7'd0;
    branch_taken = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    test_reset();
    test_addi();
    test_lw_delayed();
    test_branch();
    test_wb_select();
    test_store();
    test_ignore_ready();
    test_timeout();
    test_illegal();
    test_reset_mid_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute run-time bound in case a scenario stalls
  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
